// File: rtl/lif_neuron_core.sv
// rtl/lif_neuron_core.sv - leaky integrate-and-fire neuron core with refractory period
//
// Ports:
//   clk                clock, all state updates on rising edge
//   reset              asynchronous, active-high
//   enable             timestep strobe, one neuron update per enabled cycle
//   input_current      unsigned synaptic current for this timestep
//   threshold          unsigned firing threshold
//   decay              unsigned leak subtracted per enabled cycle
//   refractory_period  enabled cycles ignored after a spike (sampled at firing)
//   spike              registered one-cycle spike pulse
//   membrane_potential registered membrane value
//   refractory         high while in REFRACTORY state
//   spike_count        saturating count of spikes since reset
module lif_neuron_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       input_current,
  input  logic [7:0]       threshold,
  input  logic [7:0]       decay,
  input  logic [7:0]       refractory_period,
  output logic             spike,
  output logic [7:0]       membrane_potential,
  output logic             refractory,
  output logic [CNT_W-1:0] spike_count
);

  typedef enum logic {INTEGRATE = 1'b0, REFRACTORY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       v_q, v_d;
  logic [7:0]       ref_cnt_q, ref_cnt_d;
  logic             spike_q, spike_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] leaked;
  logic [8:0] sum_wide;
  logic [7:0] sum_sat;

  // Leak floors at zero, then the 9-bit sum clamps to 255 so the membrane never wraps.
  always_comb begin
    leaked   = (v_q > decay) ? (v_q - decay) : 8'd0;
    sum_wide = {1'b0, leaked} + {1'b0, input_current};
    sum_sat  = sum_wide[8] ? 8'hFF : sum_wide[7:0];
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    ref_cnt_d = ref_cnt_q;
    spike_d   = 1'b0;
    cnt_d     = cnt_q;
    if (enable) begin
      case (state_q)
        INTEGRATE: begin
          if (sum_sat >= threshold) begin
            spike_d = 1'b1;
            v_d     = 8'd0;
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
            // refractory_period is only looked at here, so later changes cannot
            // stretch or shorten a period already in progress.
            if (refractory_period != 8'd0) begin
              state_d   = REFRACTORY;
              ref_cnt_d = refractory_period;
            end
          end else begin
            v_d = sum_sat;
          end
        end
        REFRACTORY: begin
          v_d = 8'd0;
          if (ref_cnt_q <= 8'd1) begin
            ref_cnt_d = 8'd0;
            state_d   = INTEGRATE;
          end else begin
            ref_cnt_d = ref_cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = INTEGRATE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INTEGRATE;
      v_q       <= 8'd0;
      ref_cnt_q <= 8'd0;
      spike_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      ref_cnt_q <= ref_cnt_d;
      spike_q   <= spike_d;
      cnt_q     <= cnt_d;
    end
  end

  assign spike              = spike_q;
  assign membrane_potential = v_q;
  assign refractory         = (state_q == REFRACTORY);
  assign spike_count        = cnt_q;

endmodule

// File: tb/tb_lif_neuron_core.sv
// tb/tb_lif_neuron_core.sv - table-driven self-checking bench for lif_neuron_core
module tb_lif_neuron_core;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [7:0]       input_current;
  logic [7:0]       threshold;
  logic [7:0]       decay;
  logic [7:0]       refractory_period;
  logic             spike;
  logic [7:0]       membrane_potential;
  logic             refractory;
  logic [CNT_W-1:0] spike_count;

  lif_neuron_core #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .input_current      (input_current),
    .threshold          (threshold),
    .decay              (decay),
    .refractory_period  (refractory_period),
    .spike              (spike),
    .membrane_potential (membrane_potential),
    .refractory         (refractory),
    .spike_count        (spike_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic [7:0]       cur;
    logic [7:0]       thr;
    logic [7:0]       dec;
    logic [7:0]       rp;
    logic             exp_spike;
    logic [7:0]       exp_mem;
    logic             exp_refr;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp;
  int   n_bad;

  task automatic add(input logic en, input logic [7:0] cur, input logic [7:0] thr,
                     input logic [7:0] dec, input logic [7:0] rp, input logic s,
                     input logic [7:0] m, input logic r, input logic [CNT_W-1:0] c);
    vec_t v;
    v.en = en; v.cur = cur; v.thr = thr; v.dec = dec; v.rp = rp;
    v.exp_spike = s; v.exp_mem = m; v.exp_refr = r; v.exp_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic s,
                           input logic [7:0] m, input logic r, input logic [CNT_W-1:0] c);
    check({tag, ".spike"}, idx, 32'(spike), 32'(s));
    check({tag, ".mem"}, idx, 32'(membrane_potential), 32'(m));
    check({tag, ".refr"}, idx, 32'(refractory), 32'(r));
    check({tag, ".cnt"}, idx, 32'(spike_count), 32'(c));
  endtask

  task automatic drive(input logic en, input logic [7:0] cur, input logic [7:0] thr,
                       input logic [7:0] dec, input logic [7:0] rp);
    enable = en; input_current = cur; threshold = thr; decay = dec; refractory_period = rp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    reset = 1'b1;
    #12;
    check_all("reset", 0, 1'b0, 8'd0, 1'b0, '0);
    reset = 1'b0;
    #2;

    // Basic integrate / fire / refractory of length 2
    add(1, 30, 100, 0, 2, 0, 30, 0, 0);
    add(1, 30, 100, 0, 2, 0, 60, 0, 0);
    add(1, 30, 100, 0, 2, 0, 90, 0, 0);
    add(1, 30, 100, 0, 2, 1, 0, 1, 1);
    add(1, 30, 100, 0, 2, 0, 0, 1, 1);
    add(1, 30, 100, 0, 2, 0, 0, 0, 1);
    add(1, 30, 100, 0, 2, 0, 30, 0, 1);
    add(1, 30, 100, 0, 2, 0, 60, 0, 1);
    // Enable gating holds everything for 10 cycles
    for (int i = 0; i < 10; i++) add(0, 30, 100, 0, 2, 0, 60, 0, 1);
    // Leak floor: decay exceeds membrane
    add(1, 10, 200, 60, 0, 0, 10, 0, 1);
    add(1, 5, 200, 20, 0, 0, 5, 0, 1);
    add(1, 0, 200, 20, 0, 0, 0, 0, 1);
    // Saturation of the sum at 255
    add(1, 200, 255, 0, 0, 0, 200, 0, 1);
    add(1, 200, 255, 0, 0, 1, 0, 0, 2);
    // threshold=0 with refractory_period=0: fires every enabled cycle
    add(1, 0, 0, 0, 0, 1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 1, 0, 0, 4);
    add(1, 0, 0, 0, 0, 1, 0, 0, 5);
    add(1, 0, 0, 0, 0, 1, 0, 0, 6);
    add(1, 0, 0, 0, 0, 1, 0, 0, 7);
    // Gapped enable: 1,0,1
    add(1, 0, 0, 0, 0, 1, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8);
    add(1, 0, 0, 0, 0, 1, 0, 0, 9);
    // Refractory period sampled at firing; later changes and enable gaps ignored
    add(1, 60, 50, 0, 3, 1, 0, 1, 10);
    add(1, 60, 50, 0, 0, 0, 0, 1, 10);
    add(0, 60, 50, 0, 0, 0, 0, 1, 10);
    add(1, 60, 50, 0, 0, 0, 0, 1, 10);
    add(1, 60, 50, 0, 0, 0, 0, 0, 10);
    add(1, 60, 50, 0, 0, 1, 0, 0, 11);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].cur, vecs[i].thr, vecs[i].dec, vecs[i].rp);
      step();
      check_all("vec", i, vecs[i].exp_spike, vecs[i].exp_mem, vecs[i].exp_refr,
                vecs[i].exp_cnt);
    end

    // Reset in the middle of a refractory period
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1'b1, 8'd20, 8'd10, 8'd0, 8'd5);
    step();
    check_all("rst_fire", 0, 1'b1, 8'd0, 1'b1, 4'd1);
    drive(1'b1, 8'd20, 8'd10, 8'd0, 8'd5);
    step();
    check_all("rst_ign", 0, 1'b0, 8'd0, 1'b1, 4'd1);
    step();
    check_all("rst_ign", 1, 1'b0, 8'd0, 1'b1, 4'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all("rst_async", 0, 1'b0, 8'd0, 1'b0, 4'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 8'd40, 8'd100, 8'd0, 8'd5);
    step();
    check_all("rst_after", 0, 1'b0, 8'd40, 1'b0, 4'd0);

    // Async reset during a spike pulse
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    check("spk_pre", 0, 32'(spike), 32'd1);
    reset = 1'b1;
    #1;
    check_all("rst_spike", 0, 1'b0, 8'd0, 1'b0, 4'd0);
    #2;
    reset = 1'b0;

    // Spike counter saturates at 2^CNT_W-1 and firing continues
    drive(1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 20; i++) step();
    check_all("cnt_sat", 0, 1'b1, 8'd0, 1'b0, 4'd15);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
    step();
    check_all("cnt_hold", 0, 1'b0, 8'd0, 1'b0, 4'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
